// File: rtl/arm_mem_pkg.sv
// Shared types and widths for the memory-stage SRAM controller.
package arm_mem_pkg;
   localparam int SRAM_DATA_W       = 16;
   localparam int SRAM_ADDR_W       = 18;
   localparam int WORD_W            = 32;
   localparam int DEFAULT_BASE_ADDR = 1024;

   typedef enum logic [1:0] {IDLE, HIGH, WAIT, DONE} sram_state_t;
endpackage

// File: rtl/sram_dq_driver.sv
// Tri-state pad wrapper for the bidirectional 16-bit SRAM data bus.
module sram_dq_driver
   import arm_mem_pkg::*;
(
   input  logic                   i_oe,
   input  logic [SRAM_DATA_W-1:0] i_dout,
   output logic [SRAM_DATA_W-1:0] o_din,
   inout  wire  [SRAM_DATA_W-1:0] io_pad
);
   assign io_pad = i_oe ? i_dout : {SRAM_DATA_W{1'bz}};
   assign o_din  = io_pad;
endmodule

// File: rtl/sram_controller.sv
// 32-bit word access over a 16-bit async SRAM as two half-word cycles, low half first.
// Optional one-entry read cache enabled by defining SRAM_READ_CACHE_EN.
module sram_controller
   import arm_mem_pkg::*;
#(
   parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int WAIT_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [WORD_W-1:0]      address,
   input  logic [WORD_W-1:0]      write_data,
   output logic [WORD_W-1:0]      read_data,
   output logic                   ready,
   output logic                   mem_freeze,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N,
   output logic                   SRAM_WE_N
);
   localparam logic [WORD_W-1:0] LP_BASE      = 32'(BASE_ADDR);
   localparam logic [3:0]        LP_WAIT_LAST = 4'(WAIT_CYCLES - 1);

   sram_state_t            r_state, w_state_nxt;
   logic [3:0]             r_cnt;
   logic [16:0]            r_word, w_word_in;
   logic [15:0]            r_wdata_hi, r_lo, w_din, w_dout;
   logic                   r_is_wr;
   logic [WORD_W-1:0]      r_read_data, w_cache_data;
   logic                   w_req, w_start, w_hit, w_oe, w_we_n, w_ready;
   logic [SRAM_ADDR_W-1:0] w_sram_addr;

   // Requests are masked while reset is low so the pins fall back to idle asynchronously.
   assign w_req     = (wr_en | rd_en) & rst;
   assign w_word_in = 17'((address - LP_BASE) >> 2);

   sram_dq_driver u_dq (
      .i_oe   (w_oe),
      .i_dout (w_dout),
      .o_din  (w_din),
      .io_pad (SRAM_DQ)
   );

`ifdef SRAM_READ_CACHE_EN
   logic              r_cache_vld;
   logic [16:0]       r_cache_word;
   logic [WORD_W-1:0] r_cache_data;
   logic [15:0]       r_wdata_lo;

   assign w_hit = (r_state == IDLE) & rst & rd_en & ~wr_en & r_cache_vld
                  & (r_cache_word == w_word_in);
   assign w_cache_data = r_cache_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cache_vld  <= 1'b0;
         r_cache_word <= '0;
         r_cache_data <= '0;
         r_wdata_lo   <= '0;
      end else begin
         if (w_start) r_wdata_lo <= write_data[15:0];
         if (r_state == HIGH && !r_is_wr) begin
            r_cache_vld  <= 1'b1;
            r_cache_word <= r_word;
            r_cache_data <= {w_din, r_lo};
         end else if (r_state == DONE && r_is_wr && r_cache_vld && r_cache_word == r_word) begin
            r_cache_data <= {r_wdata_hi, r_wdata_lo};
         end
      end
   end
`else
   assign w_hit        = 1'b0;
   assign w_cache_data = '0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_we_n      = 1'b1;
      w_oe        = 1'b0;
      w_dout      = '0;
      w_sram_addr = '0;
      w_start     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_hit) begin
               w_ready = 1'b1;
            end else if (w_req) begin
               w_start     = 1'b1;
               w_sram_addr = {w_word_in, 1'b0};
               w_state_nxt = HIGH;
               if (wr_en) begin
                  w_we_n = 1'b0;
                  w_oe   = 1'b1;
                  w_dout = write_data[15:0];
               end
            end else begin
               w_ready = 1'b1;
            end
         end
         HIGH: begin
            w_sram_addr = {r_word, 1'b1};
            w_state_nxt = (WAIT_CYCLES == 0) ? DONE : WAIT;
            if (r_is_wr) begin
               w_we_n = 1'b0;
               w_oe   = 1'b1;
               w_dout = r_wdata_hi;
            end
         end
         WAIT: begin
            if (r_cnt == LP_WAIT_LAST) w_state_nxt = DONE;
         end
         DONE: begin
            w_ready     = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_word      <= '0;
         r_wdata_hi  <= '0;
         r_is_wr     <= 1'b0;
         r_lo        <= '0;
         r_read_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= (r_state == WAIT && r_cnt != LP_WAIT_LAST) ? r_cnt + 4'd1 : 4'd0;
         if (w_start) begin
            r_word     <= w_word_in;
            r_wdata_hi <= write_data[31:16];
            r_is_wr    <= wr_en;
            if (!wr_en) r_lo <= w_din;
         end
         if (r_state == HIGH && !r_is_wr) r_read_data <= {w_din, r_lo};
         else if (w_hit)                  r_read_data <= w_cache_data;
      end
   end

   assign read_data  = w_hit ? w_cache_data : r_read_data;
   assign ready      = w_ready;
   assign mem_freeze = (wr_en | rd_en) & ~w_ready;
   assign SRAM_ADDR  = w_sram_addr;
   assign SRAM_WE_N  = w_we_n;
   assign SRAM_UB_N  = 1'b0;
   assign SRAM_LB_N  = 1'b0;
   assign SRAM_CE_N  = 1'b0;
   assign SRAM_OE_N  = 1'b0;
endmodule
